// File: rtl/data_mem_if.sv
// Load/store port between the EX/MEM stage (master) and the data memory responder (slave).
// Both channels transfer on a rising edge where valid && ready; a raised valid holds its payload until then.
interface data_mem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_func3;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_func3, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_func3, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: sized RISC-V loads/stores, programmable
// wait states, registered response held until the consumer takes it.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   data_mem_if.slave  bus,
   output logic [1:0] state_dbg
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [3:0]  cnt;
   logic        accept, commit;
   logic        write_q;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  func3_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem [DEPTH_WORDS];

   logic          cur_write;
   logic [31:0]   cur_addr, cur_wdata;
   logic [2:0]    cur_func3;
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word, wdata_al, merged, load_data;
   logic [3:0]    be;
   logic [7:0]    lane_byte;
   logic [15:0]   lane_half;
   logic          illegal, misaligned, out_of_range, err;

   // With zero wait states the commit edge is the accept edge, so decode from the live bus in IDLE.
   assign cur_write = (state == S_IDLE) ? bus.req_write : write_q;
   assign cur_addr  = (state == S_IDLE) ? bus.req_addr  : addr_q;
   assign cur_func3 = (state == S_IDLE) ? bus.req_func3 : func3_q;
   assign cur_wdata = (state == S_IDLE) ? bus.req_wdata : wdata_q;
   assign word_idx  = cur_addr[AW+1:2];
   assign rd_word   = mem[word_idx];

   always_comb begin
      illegal      = 1'b0;
      misaligned   = 1'b0;
      out_of_range = (cur_addr >> (AW + 2)) != 32'd0;
      case (cur_func3)
         3'b000, 3'b010, 3'b001: illegal = 1'b0;
         3'b100, 3'b101:         illegal = cur_write;
         default:                illegal = 1'b1;
      endcase
      if (cur_func3[1:0] == 2'b01 && cur_addr[0])          misaligned = 1'b1;
      if (cur_func3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) misaligned = 1'b1;
      err = illegal | misaligned | out_of_range;
   end

   always_comb begin
      be        = 4'b1111;
      wdata_al  = cur_wdata;
      lane_byte = rd_word[7:0];
      case (cur_addr[1:0])
         2'd1:    lane_byte = rd_word[15:8];
         2'd2:    lane_byte = rd_word[23:16];
         2'd3:    lane_byte = rd_word[31:24];
         default: lane_byte = rd_word[7:0];
      endcase
      lane_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (cur_func3[1:0])
         2'b00: begin
            be       = 4'b0001 << cur_addr[1:0];
            wdata_al = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            be       = cur_addr[1] ? 4'b1100 : 4'b0011;
            wdata_al = {2{cur_wdata[15:0]}};
         end
         default: begin
            be       = 4'b1111;
            wdata_al = cur_wdata;
         end
      endcase
      for (int i = 0; i < 4; i++)
         merged[i*8 +: 8] = be[i] ? wdata_al[i*8 +: 8] : rd_word[i*8 +: 8];
      case (cur_func3)
         3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
         3'b100:  load_data = {24'd0, lane_byte};
         3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
         3'b101:  load_data = {16'd0, lane_half};
         default: load_data = rd_word;
      endcase
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  commit     = 1'b1;
                  state_next = S_RESP;
               end else begin
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == CNT_LAST) begin
               commit     = 1'b1;
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         func3_q <= 3'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= (state == S_WAIT) ? cnt + 4'd1 : 4'd0;
         if (accept) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            func3_q <= bus.req_func3;
            wdata_q <= bus.req_wdata;
         end
         if (commit) begin
            rdata_q <= (err || cur_write) ? 32'd0 : load_data;
            err_q   <= err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      end else if (commit && cur_write && !err) begin
         mem[word_idx] <= merged;
      end
   end

   assign bus.req_ready  = (state == S_IDLE) && rst;
   assign bus.resp_valid = (state == S_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign state_dbg      = state;

endmodule
